// File: rtl/cl_sd_sector_loader.sv
// Loads NUM_SECTORS consecutive SD sectors starting at START_ADR and streams them
// out as big-endian 32-bit words with a running word index (25 MHz SD clock domain).
module cl_sd_sector_loader #(
  parameter logic [31:0] START_ADR   = 32'h0000_0000,
  parameter int unsigned NUM_SECTORS = 4,
  parameter int unsigned IDX_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sd_ready,
  input  logic             sd_byte_available,
  input  logic [7:0]       sd_dout,
  output logic             sd_rd,
  output logic [31:0]      sd_address,
  output logic             word_valid,
  output logic [31:0]      word_data,
  output logic [IDX_W-1:0] word_index,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_READ,
    S_SECTOR_END
  } state_t;

  localparam logic [8:0] NUM_SEC9  = 9'(NUM_SECTORS);
  localparam logic [8:0] LAST_BYTE = 9'd511;

  state_t      state;
  logic        avail_q;
  logic        rd_acked;
  logic [8:0]  byte_cnt;
  logic [7:0]  sector_cnt;
  logic [23:0] word_buf;
  logic        byte_take;
  logic        last_sector;

  assign byte_take   = sd_byte_available & ~avail_q;
  assign last_sector = ({1'b0, sector_cnt} + 9'd1) == NUM_SEC9;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      avail_q    <= 1'b0;
      rd_acked   <= 1'b0;
      byte_cnt   <= '0;
      sector_cnt <= '0;
      word_buf   <= '0;
      sd_rd      <= 1'b0;
      sd_address <= START_ADR;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_index <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      avail_q    <= sd_byte_available;
      word_valid <= 1'b0;
      // Index advances the cycle after its strobe; a start in IDLE overrides below.
      if (word_valid) word_index <= word_index + IDX_W'(1);

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_ISSUE;
            done       <= 1'b0;
            error      <= 1'b0;
            word_index <= '0;
            sd_address <= START_ADR;
            sector_cnt <= '0;
            byte_cnt   <= '0;
            rd_acked   <= 1'b0;
            busy       <= 1'b1;
            sd_rd      <= 1'b1;
          end
        end

        S_ISSUE: begin
          // The controller must first see rd with ready high, then drop ready.
          if (sd_rd && sd_ready) rd_acked <= 1'b1;
          if (sd_rd && rd_acked && !sd_ready) begin
            sd_rd    <= 1'b0;
            rd_acked <= 1'b0;
            byte_cnt <= '0;
            state    <= S_READ;
          end
        end

        S_READ: begin
          if (sd_ready && !(byte_take && byte_cnt == LAST_BYTE)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (byte_take) begin
            word_buf <= {word_buf[15:0], sd_dout};
            byte_cnt <= byte_cnt + 9'd1;
            if (byte_cnt[1:0] == 2'd3) begin
              word_data  <= {word_buf, sd_dout};
              word_valid <= 1'b1;
            end
            if (byte_cnt == LAST_BYTE) state <= S_SECTOR_END;
          end
        end

        S_SECTOR_END: begin
          if (sd_ready) begin
            if (last_sector) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              sd_address <= sd_address + 32'd512;
              sector_cnt <= sector_cnt + 8'd1;
              rd_acked   <= 1'b0;
              sd_rd      <= 1'b1;
              state      <= S_ISSUE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_sd_sector_loader.sv
// Bench for cl_sd_sector_loader: behavioural SD controller model feeding bytes,
// scoreboard of expected words, directed scenarios in one initial block.
module tb_cl_sd_sector_loader;

  localparam logic [31:0] START = 32'h0000_0000;
  localparam int unsigned NSEC  = 2;
  localparam int unsigned IW    = 10;

  logic          clk;
  logic          reset;
  logic          start;
  logic          sd_ready;
  logic          sd_byte_available;
  logic [7:0]    sd_dout;
  logic          sd_rd;
  logic [31:0]   sd_address;
  logic          word_valid;
  logic [31:0]   word_data;
  logic [IW-1:0] word_index;
  logic          busy;
  logic          done;
  logic          error;

  cl_sd_sector_loader #(
    .START_ADR  (START),
    .NUM_SECTORS(NSEC),
    .IDX_W      (IW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .sd_ready         (sd_ready),
    .sd_byte_available(sd_byte_available),
    .sd_dout          (sd_dout),
    .sd_rd            (sd_rd),
    .sd_address       (sd_address),
    .word_valid       (word_valid),
    .word_data        (word_data),
    .word_index       (word_index),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct packed {
    logic [31:0]   data;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t        sc_q[$];
  logic [31:0] rd_addrs[$];

  int n_pass  = 0;
  int n_total = 0;
  int exp_idx = 0;
  int n_strobes = 0;
  int last_idx = -1;
  logic [31:0] w0, w127, w128;

  // SD model configuration and state
  int stretch   = 1;
  int short_n   = 512;
  int block_cnt = 0;
  int m_state   = 0;
  int m_byte    = 0;
  int m_phase   = 0;
  int m_wait    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Behavioural SD controller: accepts rd while ready, then streams short_n bytes.
  initial begin
    exp_t e;
    sd_ready          = 1'b1;
    sd_byte_available = 1'b0;
    sd_dout           = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_state           = 0;
        sd_ready          = 1'b1;
        sd_byte_available = 1'b0;
        block_cnt         = 0;
      end else begin
        case (m_state)
          0: begin
            if (block_cnt > 0) begin
              block_cnt--;
              sd_ready = 1'b0;
            end else begin
              sd_ready = 1'b1;
            end
            if (sd_ready && sd_rd) m_state = 1;
          end
          1: begin
            sd_ready = 1'b0;
            rd_addrs.push_back(sd_address);
            m_byte  = 0;
            m_phase = 0;
            m_wait  = 3;
            m_state = 2;
          end
          2: begin
            if (m_wait > 0) begin
              m_wait--;
            end else begin
              if (m_phase < stretch) begin
                sd_byte_available = 1'b1;
                if (m_phase == 0) begin
                  sd_dout = 8'(m_byte);
                  if (m_byte % 4 == 3) begin
                    e.data = {8'(m_byte - 3), 8'(m_byte - 2), 8'(m_byte - 1), 8'(m_byte)};
                    e.idx  = IW'(exp_idx);
                    sc_q.push_back(e);
                    exp_idx++;
                  end
                end
              end else begin
                sd_byte_available = 1'b0;
              end
              m_phase++;
              if (m_phase == stretch + 2) begin
                m_phase = 0;
                m_byte++;
                if (m_byte == short_n) begin
                  m_state = 3;
                  m_wait  = 4;
                end
              end
            end
          end
          3: begin
            if (m_wait > 0) m_wait--;
            else begin
              sd_ready = 1'b1;
              m_state  = 0;
            end
          end
          default: m_state = 0;
        endcase
      end
    end
  end

  // Output monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    exp_t e;
    if (word_valid) begin
      n_strobes++;
      last_idx = int'(word_index);
      if (word_index == 0)   w0   = word_data;
      if (word_index == 127) w127 = word_data;
      if (word_index == 128) w128 = word_data;
      check("strobe_has_expected_word", 64'(sc_q.size() > 0), 64'd1);
      if (sc_q.size() > 0) begin
        e = sc_q.pop_front();
        check("word_data", 64'(word_data), 64'(e.data));
        check("word_index", 64'(word_index), 64'(e.idx));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load();
    exp_idx   = 0;
    n_strobes = 0;
    last_idx  = -1;
    w0 = '0; w127 = '0; w128 = '0;
    rd_addrs.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int c = 0;
    while (!(done || error) && c < 8000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_finished_in_time"}, 64'(c < 8000), 64'd1);
  endtask

  task automatic wait_strobes(input string tag, input int n);
    int c = 0;
    while (n_strobes < n && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_strobes_reached"}, 64'(c < 5000), 64'd1);
  endtask

  task automatic load_checks(input string tag);
    check({tag, "_done"},      64'(done), 64'd1);
    check({tag, "_busy"},      64'(busy), 64'd0);
    check({tag, "_error"},     64'(error), 64'd0);
    check({tag, "_strobes"},   64'(n_strobes), 64'd256);
    check({tag, "_last_idx"},  64'(last_idx), 64'd255);
    check({tag, "_sb_empty"},  64'(sc_q.size()), 64'd0);
    check({tag, "_w0"},        64'(w0),   64'h0001_0203);
    check({tag, "_w127"},      64'(w127), 64'hFCFD_FEFF);
    check({tag, "_w128"},      64'(w128), 64'h0001_0203);
    check({tag, "_num_reads"}, 64'(rd_addrs.size()), 64'd2);
    check({tag, "_addr0"}, 64'((rd_addrs.size() > 0) ? rd_addrs[0] : 32'hDEAD_BEEF), 64'(START));
    check({tag, "_addr1"}, 64'((rd_addrs.size() > 1) ? rd_addrs[1] : 32'hDEAD_BEEF),
          64'(START + 32'd512));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_sd_rd"},      64'(sd_rd), 64'd0);
    check({tag, "_sd_address"}, 64'(sd_address), 64'(START));
    check({tag, "_word_valid"}, 64'(word_valid), 64'd0);
    check({tag, "_word_data"},  64'(word_data), 64'd0);
    check({tag, "_word_index"}, 64'(word_index), 64'd0);
    check({tag, "_busy"},       64'(busy), 64'd0);
    check({tag, "_done"},       64'(done), 64'd0);
    check({tag, "_error"},      64'(error), 64'd0);
  endtask

  initial begin
    bit rd_held;
    reset = 1'b1;
    start = 1'b0;
    repeat (4) tick();
    reset_checks("reset");

    // start coinciding with the last reset cycle must be ignored
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    tick();
    check("start_with_reset_ignored", 64'(busy), 64'd0);

    // Basic load
    stretch = 1;
    begin_load();
    check("basic_busy_after_start", 64'(busy), 64'd1);
    wait_end("basic");
    load_checks("basic");
    tick();

    // Stretched byte_available
    stretch = 3;
    begin_load();
    wait_end("stretch");
    load_checks("stretch");
    stretch = 1;
    tick();

    // Slow ready: rd must be held until the controller takes it
    block_cnt = 20;
    begin_load();
    rd_held = 1'b1;
    repeat (18) begin
      @(negedge clk);
      if (!sd_rd) rd_held = 1'b0;
    end
    check("slow_rd_held", 64'(rd_held), 64'd1);
    check("slow_no_early_read", 64'(rd_addrs.size()), 64'd0);
    wait_end("slow");
    load_checks("slow");
    tick();

    // Short sectors: 300 bytes (whole words) and 302 bytes (trailing partial word)
    for (int s = 0; s < 2; s++) begin
      short_n = (s == 0) ? 300 : 302;
      begin_load();
      wait_end("short");
      check("short_error",    64'(error), 64'd1);
      check("short_done",     64'(done), 64'd0);
      check("short_busy",     64'(busy), 64'd0);
      check("short_strobes",  64'(n_strobes), 64'd75);
      check("short_last_idx", 64'(last_idx), 64'd74);
      check("short_sb_empty", 64'(sc_q.size()), 64'd0);
      repeat (10) tick();
      check("short_no_late_strobe", 64'(n_strobes), 64'd75);
    end
    short_n = 512;

    // Reset mid-load, then reload
    begin_load();
    wait_strobes("midreset", 50);
    reset = 1'b1;
    repeat (3) tick();
    sc_q.delete();
    reset_checks("midreset");
    reset = 1'b0;
    tick();
    begin_load();
    wait_end("reload");
    load_checks("reload");
    tick();

    // start while busy is ignored; start after done restarts
    begin_load();
    wait_strobes("busystart", 100);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busystart_still_busy", 64'(busy), 64'd1);
    wait_end("busystart");
    load_checks("busystart");
    tick();
    begin_load();
    check("restart_done_cleared", 64'(done), 64'd0);
    wait_end("restart");
    load_checks("restart");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
